// File: rtl/tdc_decoder.sv
// -----------------------------------------------------------------------------
// tdc_decoder
//
// Consumer of the thermometer-code TDC delay line in the SRAM BIST path.
// For each measurement the block:
//   - re-arms the TDC;
//   - captures one code per sample;
//   - decodes the code to a delay count by popcount, so bubbles are tolerated;
//   - accumulates sum/min/max plus a count of saturated (all-ones) samples.
// The result is then offered to the BIST controller over valid/ready.
//
// Optional feature (macro TDC_DECODER_BUBBLE_CHECK_EN):
//   Adds output result_bubbles. It counts the samples whose code is not a
//   clean thermometer, i.e. a 1 sits above a 0.
//
// Ports:
//   clock          block clock
//   reset          synchronous, active-high reset
//   start          one-cycle measurement request (honoured only when idle)
//   num_samples    sample count latched at start; 0 means 2^NS_WIDTH
//   tdc_reset_b    active-low clear to the TDC output register
//   sample_valid   TDC has captured a code (already synchronised)
//   sample_data    TDC code, stable while sample_valid is high
//   busy           high whenever the FSM is not idle
//   result_valid   result available; result_* stable while high
//   result_ready   consumer accepts the result
//   result_sum     sum of decoded counts
//   result_min     minimum decoded count
//   result_max     maximum decoded count
//   result_sat     number of all-ones samples (saturating)
//   result_bubbles number of non-thermometer samples (macro only, saturating)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tdc_decoder #(
  parameter int DATA_WIDTH = 252,
  parameter int CNT_WIDTH  = 8,
  parameter int NS_WIDTH   = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NS_WIDTH-1:0]   num_samples,
  output logic                  tdc_reset_b,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [ACC_WIDTH-1:0]  result_sum,
  output logic [CNT_WIDTH-1:0]  result_min,
  output logic [CNT_WIDTH-1:0]  result_max,
  output logic [NS_WIDTH-1:0]   result_sat
`ifdef TDC_DECODER_BUBBLE_CHECK_EN
  ,
  output logic [NS_WIDTH-1:0]   result_bubbles
`endif
);

  // The popcount is split into six equal slices so that each pipeline stage
  // holds only a modest adder tree.
  localparam int NUM_SLICES = 6;
  localparam int SLICE_W    = DATA_WIDTH / NUM_SLICES;
  localparam int SC_W       = $clog2(SLICE_W + 1);

  localparam logic [NS_WIDTH-1:0]  NS_ONE    = NS_WIDTH'(1);
  localparam logic [NS_WIDTH-1:0]  NS_ALL1   = {NS_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ALL1  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DEC1  = 3'd3,
    ST_DEC2  = 3'd4,
    ST_REARM = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Population count of one slice of the captured code.
  function automatic logic [SC_W-1:0] popcount_slice(input logic [SLICE_W-1:0] v);
    logic [SC_W-1:0] n;
    n = {SC_W{1'b0}};
    for (int i = 0; i < SLICE_W; i++) begin
      n = n + {{(SC_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  state_t                state_q, state_d;
  logic [NS_WIDTH-1:0]   remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic [SC_W-1:0]       slice_cnt_q [NUM_SLICES];
  logic [SC_W-1:0]       slice_cnt_d [NUM_SLICES];
  logic [ACC_WIDTH-1:0]  sum_q, sum_d;
  logic [CNT_WIDTH-1:0]  min_q, min_d;
  logic [CNT_WIDTH-1:0]  max_q, max_d;
  logic [NS_WIDTH-1:0]   sat_q, sat_d;
  logic                  tdc_reset_b_q, tdc_reset_b_d;
  logic                  busy_q, busy_d;
  logic                  result_valid_q, result_valid_d;
  logic [CNT_WIDTH-1:0]  count_s;

  // Second decode stage: add the six slice counts into one sample count.
  always_comb begin
    count_s = {CNT_WIDTH{1'b0}};
    for (int k = 0; k < NUM_SLICES; k++) begin
      count_s = count_s + CNT_WIDTH'(slice_cnt_q[k]);
    end
  end

  // FSM next state, capture/decode pipeline and accumulators.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sample_d    = sample_q;
    sum_d       = sum_q;
    min_d       = min_q;
    max_d       = max_q;
    sat_d       = sat_q;
    for (int k = 0; k < NUM_SLICES; k++) begin
      slice_cnt_d[k] = slice_cnt_q[k];
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = num_samples;
          sum_d       = {ACC_WIDTH{1'b0}};
          min_d       = CNT_ALL1;
          max_d       = {CNT_WIDTH{1'b0}};
          sat_d       = {NS_WIDTH{1'b0}};
          state_d     = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sample_valid) begin
          sample_d = sample_data;
          state_d  = ST_DEC1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DEC1: begin
        for (int k = 0; k < NUM_SLICES; k++) begin
          slice_cnt_d[k] = popcount_slice(sample_q[k*SLICE_W +: SLICE_W]);
        end
        state_d = ST_DEC2;
      end
      ST_DEC2: begin
        sum_d = sum_q + ACC_WIDTH'(count_s);
        if (count_s < min_q) begin
          min_d = count_s;
        end else begin
          min_d = min_q;
        end
        if (count_s > max_q) begin
          max_d = count_s;
        end else begin
          max_d = max_q;
        end
        if ((count_s == CNT_FULL) && (sat_q != NS_ALL1)) begin
          sat_d = sat_q + NS_ONE;
        end else begin
          sat_d = sat_q;
        end
        // A request of 0 wraps the counter, so it runs for 2^NS_WIDTH samples.
        remaining_d = remaining_q - NS_ONE;
        if (remaining_q == NS_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_REARM;
        end
      end
      ST_REARM: begin
        state_d = ST_ARM;
      end
      ST_DONE: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they come straight off flops.
  always_comb begin
    busy_d         = (state_d != ST_IDLE);
    result_valid_d = (state_d == ST_DONE);
    case (state_d)
      ST_ARM, ST_WAIT, ST_DEC1, ST_DEC2: tdc_reset_b_d = 1'b1;
      default:                           tdc_reset_b_d = 1'b0;
    endcase
  end

  // State, pipeline, accumulator and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      remaining_q    <= {NS_WIDTH{1'b0}};
      sample_q       <= {DATA_WIDTH{1'b0}};
      sum_q          <= {ACC_WIDTH{1'b0}};
      min_q          <= CNT_ALL1;
      max_q          <= {CNT_WIDTH{1'b0}};
      sat_q          <= {NS_WIDTH{1'b0}};
      tdc_reset_b_q  <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      for (int k = 0; k < NUM_SLICES; k++) begin
        slice_cnt_q[k] <= {SC_W{1'b0}};
      end
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      sample_q       <= sample_d;
      sum_q          <= sum_d;
      min_q          <= min_d;
      max_q          <= max_d;
      sat_q          <= sat_d;
      tdc_reset_b_q  <= tdc_reset_b_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      for (int k = 0; k < NUM_SLICES; k++) begin
        slice_cnt_q[k] <= slice_cnt_d[k];
      end
    end
  end

  assign tdc_reset_b  = tdc_reset_b_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_sum   = sum_q;
  assign result_min   = min_q;
  assign result_max   = max_q;
  assign result_sat   = sat_q;

`ifdef TDC_DECODER_BUBBLE_CHECK_EN
  logic                bubble_flag_q, bubble_flag_d;
  logic [NS_WIDTH-1:0] bubbles_q, bubbles_d;

  // Flag a code where a 1 sits directly above a 0, then count flagged samples.
  always_comb begin
    bubble_flag_d = bubble_flag_q;
    bubbles_d     = bubbles_q;
    if (state_q == ST_DEC1) begin
      bubble_flag_d = |(sample_q[DATA_WIDTH-1:1] & ~sample_q[DATA_WIDTH-2:0]);
    end else begin
      bubble_flag_d = bubble_flag_q;
    end
    if ((state_q == ST_IDLE) && start) begin
      bubbles_d = {NS_WIDTH{1'b0}};
    end else if ((state_q == ST_DEC2) && bubble_flag_q && (bubbles_q != NS_ALL1)) begin
      bubbles_d = bubbles_q + NS_ONE;
    end else begin
      bubbles_d = bubbles_q;
    end
  end

  // Bubble flag and bubble counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      bubble_flag_q <= 1'b0;
      bubbles_q     <= {NS_WIDTH{1'b0}};
    end else begin
      bubble_flag_q <= bubble_flag_d;
      bubbles_q     <= bubbles_d;
    end
  end

  assign result_bubbles = bubbles_q;
`else
  // Without bubble checking the decode is pure popcount and keeps no bubble state.
`endif

endmodule

// File: tb/tb_tdc_decoder.sv
`timescale 1ns/1ps

module tb_tdc_decoder;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   num_samples;
  logic         tdc_reset_b;
  logic         sample_valid;
  logic [251:0] sample_data;
  logic         busy;
  logic         result_valid;
  logic         result_ready;
  logic [15:0]  result_sum;
  logic [7:0]   result_min;
  logic [7:0]   result_max;
  logic [7:0]   result_sat;
`ifdef TDC_DECODER_BUBBLE_CHECK_EN
  logic [7:0]   result_bubbles;
`endif

  tdc_decoder dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .num_samples  (num_samples),
    .tdc_reset_b  (tdc_reset_b),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_sum   (result_sum),
    .result_min   (result_min),
    .result_max   (result_max),
    .result_sat   (result_sat)
`ifdef TDC_DECODER_BUBBLE_CHECK_EN
    ,
    .result_bubbles (result_bubbles)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;
  int rearm_cnt = 0;
  logic [251:0] codes[$];

  // Cycles spent clearing the TDC between samples of a measurement.
  always @(negedge clock) begin
    if (busy && !tdc_reset_b && !result_valid) rearm_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [251:0] make_therm(input int k);
    logic [251:0] ones;
    ones = '1;
    if (k <= 0) return '0;
    return ones >> (252 - k);
  endfunction

  function automatic logic [251:0] rand_code();
    logic [251:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[219:0], 32'($urandom())};
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; start = 1'b0; sample_valid = 1'b0; result_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_idle_reset_values(input string name);
    check_eq({name, "_tdc_reset_b"}, tdc_reset_b, 0);
    check_eq({name, "_busy"}, busy, 0);
    check_eq({name, "_valid"}, result_valid, 0);
    check_eq({name, "_sum"}, result_sum, 0);
    check_eq({name, "_min"}, result_min, 255);
    check_eq({name, "_max"}, result_max, 0);
    check_eq({name, "_sat"}, result_sat, 0);
  endtask

  // Acts as the TDC for every code in 'codes' and checks the final result.
  task automatic measure(input logic [7:0] ns_in, input bit poke_start, input string name);
    int n, c, cnt, rb, hold;
    int exp_sum, exp_min, exp_max, exp_sat, exp_bub;
    logic [15:0] held_sum;
    n = codes.size();
    exp_sum = 0; exp_min = 255; exp_max = 0; exp_sat = 0; exp_bub = 0;
    foreach (codes[i]) begin
      c = $countones(codes[i]);
      exp_sum += c;
      if (c < exp_min) exp_min = c;
      if (c > exp_max) exp_max = c;
      if (c == 252) exp_sat++;
      if (codes[i] != make_therm(c)) exp_bub++;
    end
    if (exp_sat > 255) exp_sat = 255;
    if (exp_bub > 255) exp_bub = 255;
    rb = rearm_cnt;

    @(negedge clock);
    start = 1'b1; num_samples = ns_in;
    @(negedge clock);
    start = 1'b0; num_samples = 8'($urandom());
    for (int i = 0; i < n; i++) begin
      cnt = 0;
      while (!tdc_reset_b && cnt < 40) begin @(negedge clock); cnt++; end
      if (!tdc_reset_b) begin
        check_eq({name, "_arm_timeout"}, cnt, 0);
        do_reset();
        return;
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
      if (poke_start && i == 0) start = 1'b1;
      sample_data = codes[i];
      sample_valid = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cnt = 0;
      while (tdc_reset_b && cnt < 40) begin @(negedge clock); cnt++; end
      if (tdc_reset_b) begin
        check_eq({name, "_consume_timeout"}, cnt, 0);
        do_reset();
        return;
      end
      sample_valid = 1'b0;
      sample_data = rand_code();
    end

    cnt = 0;
    while (!result_valid && cnt < 20) begin @(negedge clock); cnt++; end
    check_eq({name, "_valid"}, result_valid, 1);
    if (!result_valid) begin
      do_reset();
      return;
    end
    check_eq({name, "_sum"}, result_sum, exp_sum);
    check_eq({name, "_min"}, result_min, exp_min);
    check_eq({name, "_max"}, result_max, exp_max);
    check_eq({name, "_sat"}, result_sat, exp_sat);
    check_eq({name, "_rearms"}, rearm_cnt - rb, n - 1);
`ifdef TDC_DECODER_BUBBLE_CHECK_EN
    check_eq({name, "_bubbles"}, result_bubbles, exp_bub);
`endif

    // Hold off the consumer for a while; start pulses here must be ignored.
    held_sum = 16'(exp_sum);
    hold = $urandom_range(1, 3);
    for (int j = 0; j < hold; j++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clock);
      start = 1'b0;
    end
    check_eq({name, "_valid_hold"}, result_valid, 1);
    check_eq({name, "_sum_hold"}, result_sum, held_sum);
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    check_eq({name, "_valid_drop"}, result_valid, 0);
    check_eq({name, "_busy_drop"}, busy, 0);
    check_eq({name, "_sum_idle"}, result_sum, held_sum);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [251:0] v;
    int cnt;
    reset = 1'b1; start = 1'b0; num_samples = 8'd0;
    sample_valid = 1'b0; sample_data = '0; result_ready = 1'b0;

    // Reset then idle.
    @(negedge clock);
    @(negedge clock);
    check_idle_reset_values("reset");
    reset = 1'b0;

    // Single sample of 100 ones.
    codes.delete();
    codes.push_back(make_therm(100));
    measure(8'd1, 1'b0, "single");

    // Four samples: 10, 200, 0, 252.
    codes.delete();
    codes.push_back(make_therm(10));
    codes.push_back(make_therm(200));
    codes.push_back(make_therm(0));
    codes.push_back(make_therm(252));
    measure(8'd4, 1'b0, "four");

    // num_samples=0: 256 all-ones samples, saturating sat.
    codes.delete();
    for (int i = 0; i < 256; i++) codes.push_back(make_therm(252));
    measure(8'd0, 1'b0, "full_ones");

    // num_samples=0: 256 all-zero samples.
    codes.delete();
    for (int i = 0; i < 256; i++) codes.push_back('0);
    measure(8'd0, 1'b0, "full_zeros");

    // Bubble code: bits 0-49 and 52-59 set.
    v = make_therm(60) & ~(make_therm(52) ^ make_therm(50));
    codes.delete();
    codes.push_back(v);
    measure(8'd1, 1'b0, "bubble");

    // Reset while decoding the second sample of a three-sample request.
    @(negedge clock);
    start = 1'b1; num_samples = 8'd3;
    @(negedge clock);
    start = 1'b0;
    cnt = 0;
    while (!tdc_reset_b && cnt < 40) begin @(negedge clock); cnt++; end
    sample_data = make_therm(30); sample_valid = 1'b1;
    cnt = 0;
    @(negedge clock);
    while (tdc_reset_b && cnt < 40) begin @(negedge clock); cnt++; end
    sample_valid = 1'b0;
    cnt = 0;
    while (!tdc_reset_b && cnt < 40) begin @(negedge clock); cnt++; end
    check_eq("disrupt_armed", tdc_reset_b, 1);
    @(negedge clock);
    sample_data = make_therm(40); sample_valid = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_idle_reset_values("disrupt");
    reset = 1'b0; sample_valid = 1'b0;

    codes.delete();
    codes.push_back(make_therm(7));
    measure(8'd1, 1'b0, "post_reset");

    // start pulsed while busy is ignored.
    codes.delete();
    codes.push_back(make_therm($urandom_range(0, 252)));
    codes.push_back(rand_code());
    measure(8'd2, 1'b1, "poke");

    // Randomised measurements.
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(1, 6);
      codes.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: codes.push_back(make_therm($urandom_range(0, 252)));
          1: codes.push_back(make_therm(252));
          2: codes.push_back(rand_code());
          default: begin
            v = make_therm($urandom_range(0, 252));
            v[$urandom_range(0, 251)] ^= 1'b1;
            codes.push_back(v);
          end
        endcase
      end
      measure(8'(n), 1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tdc_decoder.md
Name: tdc_decoder

Overview:
- Downstream consumer of the 252-bit thermometer-code TDC delay line in the sram-bist path.
- Re-arms the TDC, captures each sample and decodes it to a delay count by popcount (tolerant of bubbles).
- Accumulates N samples into sum/min/max.
- Presents the result to the BIST controller over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 252, thermometer code width from the TDC.
- CNT_WIDTH, 8, width of one decoded sample; must satisfy 2^CNT_WIDTH > DATA_WIDTH.
- NS_WIDTH, 8, width of the sample-count request.
- ACC_WIDTH, 16, width of the accumulated sum; must be >= CNT_WIDTH+NS_WIDTH.

Ports:
- clock  input  1  block clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a measurement; ignored unless idle.
- num_samples  input  NS_WIDTH  samples to take, latched at start; 0 means 2^NS_WIDTH.
- tdc_reset_b  output  1  active-low clear to the TDC output register.
- sample_valid  input  1  level, already synchronised into clock; high once the TDC stop edge has captured a code.
- sample_data  input  DATA_WIDTH  TDC dout; stable while sample_valid=1.
- busy  output  1  high in every state except IDLE.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts the result.
- result_sum  output  ACC_WIDTH  sum of decoded counts.
- result_min  output  CNT_WIDTH  minimum decoded count.
- result_max  output  CNT_WIDTH  maximum decoded count.
- result_sat  output  NS_WIDTH  number of samples that were all-ones (delay-line overflow).

Behaviour:
- Reset values: tdc_reset_b=0, busy=0, result_valid=0, result_sum=0, result_min=all-ones, result_max=0, result_sat=0. The FSM enters IDLE.
- IDLE: tdc_reset_b=0 (TDC held clear). When start=1:
  - Latch num_samples into the remaining counter.
  - Clear the accumulators to the reset values.
  - Go to ARM.
- ARM: lasts exactly one cycle with tdc_reset_b=1, then go to WAIT.
- WAIT:
  - tdc_reset_b=1.
  - When sample_valid=1, register sample_data into stage-1 and go to DEC1.
  - There is no timeout; the BIST controller aborts by asserting reset.
- DEC1: stage-1 computes popcounts of six 42-bit slices into registers; go to DEC2.
- DEC2:
  - Sum the six slice counts into c (CNT_WIDTH bits).
  - sum += c; min = min(min,c); max = max(max,c).
  - If c==DATA_WIDTH, sat += 1, saturating at all-ones.
  - Decrement remaining.
  - If remaining was 1, go to DONE; otherwise go to REARM.
- REARM: tdc_reset_b=0 for one cycle, then go to ARM. This clears the previous code before the next capture.
- DONE:
  - result_valid=1 and all result_* outputs are held stable.
  - On result_valid & result_ready, go to IDLE and drop result_valid the next cycle.
  - Result registers keep their values in IDLE until the next start.
- Latency per sample: WAIT exit to accumulator update is 2 cycles.
- Minimum cycles per sample: 5 (ARM, WAIT, DEC1, DEC2, REARM), with sample_valid already high.
- start outside IDLE has no effect.
- With num_samples=0, exactly 256 samples are taken.
- sample_valid high in any state other than WAIT is ignored.
- The sum cannot overflow at the default parameters: 252×256 = 64512 < 2^16.
- Reset asserted in any state returns to IDLE next cycle with all outputs at their reset values. Any partial accumulation is discarded.

Optional Feature:
- Macro: TDC_DECODER_BUBBLE_CHECK_EN.
- With the macro defined:
  - Add output result_bubbles (NS_WIDTH).
  - In DEC1, flag the sample if any bit i≥1 has sample_data[i]=1 while sample_data[i-1]=0, i.e. the code is not a clean thermometer.
  - In DEC2, the count of flagged samples increments, saturating.
  - The counter resets with the other accumulators at start.
- Without the macro: the port and its logic are absent. Decode is pure popcount either way.

Test Plan:
- Reset then idle: hold reset 2 cycles → tdc_reset_b=0, busy=0, result_valid=0, result_min=255, result_max=0.
- Single sample: num_samples=1, start, sample_data = lower 100 bits set → result_sum=100, min=100, max=100, sat=0. result_valid holds until result_ready, then drops the next cycle.
- Four samples with counts 10, 200, 0, 252 → sum=462, min=0, max=252, sat=1. tdc_reset_b pulses low once between each pair of samples (3 REARM pulses).
- num_samples=0, every sample all-ones → exactly 256 samples consumed, sum=64512, sat=255 (saturated). With the macro on, 256 all-zero samples → bubbles=0.
- Bubble code, macro on: bits 0–49 and 52–59 set (58 ones) → result_sum=58, result_bubbles=1.
- Disruptions: reset asserted during DEC1 of sample 2 → IDLE next cycle, outputs at reset values. A later start with 1 sample of 7 ones → sum=7. start pulsed while busy → ignored, no extra samples taken.
